// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake,
// divide-by-zero short-circuits straight to DONE with saturated outputs.
module div_seq_ctrl #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quo,
    output logic [VW-1:0] rem,
    output logic          dz
);

    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(DW);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    r_state;
    logic [DW-1:0] r_d;
    logic [VW-1:0] r_v;
    logic [VW:0]   r_p;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_quo;
    logic [VW-1:0] r_rem;
    logic          r_dz;

    logic [VW:0]   w_t;
    logic [VW:0]   w_vx;
    logic          w_ge;
    logic [VW:0]   w_pn;
    logic [DW-1:0] w_dn;

    // One extra bit on the trial value so the shifted-in remainder cannot overflow.
    assign w_t  = {r_p[VW-1:0], r_d[DW-1]};
    assign w_vx = {1'b0, r_v};
    assign w_ge = (w_t >= w_vx);
    assign w_pn = w_ge ? (w_t - w_vx) : w_t;
    assign w_dn = {r_d[DW-2:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_d     <= '0;
            r_v     <= '0;
            r_p     <= '0;
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            r_state <= DONE;
                            r_quo   <= '1;
                            r_rem   <= '1;
                            r_dz    <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_d     <= dividend;
                            r_v     <= divisor;
                            r_p     <= '0;
                            r_cnt   <= CNT_INIT;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_d   <= w_dn;
                    r_p   <= w_pn;
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_state <= DONE;
                        r_quo   <= w_dn;
                        r_rem   <= w_pn[VW-1:0];
                        r_dz    <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign quo  = r_quo;
    assign rem  = r_rem;
    assign dz   = r_dz;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Randomized self-checking bench for div_seq_ctrl against an arithmetic
// reference (integer / and %), plus directed handshake and reset scenarios.
module tb_div_seq_ctrl;

    localparam int DW = 8;
    localparam int VW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quo;
    logic [VW-1:0] rem;
    logic          dz;

    int n_checks;
    int n_errors;
    int done_cnt;

    div_seq_ctrl #(.DW(DW), .VW(VW)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quo      (quo),
        .rem      (rem),
        .dz       (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_div(input logic [DW-1:0] a, input logic [VW-1:0] b);
        int cyc;
        int busy_cyc;
        int exp_lat;
        logic [DW-1:0] eq;
        logic [VW-1:0] er;
        logic          edz;
        if (b == 0) begin
            eq = {DW{1'b1}}; er = {VW{1'b1}}; edz = 1'b1; exp_lat = 1;
        end else begin
            eq = DW'(int'(a) / int'(b));
            er = VW'(int'(a) % int'(b));
            edz = 1'b0; exp_lat = DW + 1;
        end
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 1; busy_cyc = 0;
        @(negedge clk);
        while (!done && cyc < 40) begin
            if (busy) busy_cyc++;
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check_val("latency", cyc, exp_lat);
        check_val("busy_cycles", busy_cyc, edz ? 0 : DW);
        check_val("busy_in_done", busy, 0);
        check_val("quo", quo, eq);
        check_val("rem", rem, er);
        check_val("dz", dz, edz);
        @(negedge clk);
        check_val("done_pulse_width", done, 0);
        check_val("quo_hold", quo, eq);
        check_val("rem_hold", rem, er);
    endtask

    initial begin
        int cyc;
        int d0;
        int first_done;
        int second_done;

        n_checks = 0; n_errors = 0; done_cnt = 0;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_quo", quo, 0);
        check_val("rst_rem", rem, 0);
        check_val("rst_dz", dz, 0);
        @(negedge clk);
        rst = 1'b0;

        do_div(8'd200, 4'd7);
        do_div(8'd255, 4'd15);
        do_div(8'd5, 4'd9);
        do_div(8'd100, 4'd0);
        do_div(8'd9, 4'd3);

        // start pulsed while running must be ignored
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 4'd5;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(negedge clk);
        check_val("ignore_done_count", done_cnt - d0, 1);
        check_val("ignore_quo", quo, 28);
        check_val("ignore_rem", rem, 4);

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("arst_busy", busy, 0);
        check_val("arst_done", done, 0);
        check_val("arst_quo", quo, 0);
        check_val("arst_rem", rem, 0);
        check_val("arst_dz", dz, 0);
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check_val("arst_no_done", done_cnt - d0, 0);
        check_val("arst_idle_busy", busy, 0);
        do_div(8'd64, 4'd8);

        // back-to-back: start held through DONE with new operands
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        cyc = 0; first_done = 0; second_done = 0;
        while (second_done == 0 && cyc < 40) begin
            @(posedge clk);
            cyc++;
            if (first_done != 0 && start) #1 start = 1'b0;
            @(negedge clk);
            if (done) begin
                if (first_done == 0) begin
                    first_done = cyc;
                    check_val("b2b_quo1", quo, 28);
                    check_val("b2b_rem1", rem, 4);
                    dividend = 8'd17; divisor = 4'd4;
                end else begin
                    second_done = cyc;
                end
            end
        end
        start = 1'b0;
        check_val("b2b_first_done_cycle", first_done, 9);
        check_val("b2b_second_done_cycle", second_done, 18);
        check_val("b2b_quo2", quo, 4);
        check_val("b2b_rem2", rem, 1);
        check_val("b2b_dz2", dz, 0);

        for (int i = 0; i < 40; i++) begin
            logic [DW-1:0] ra;
            logic [VW-1:0] rb;
            ra = DW'($urandom_range(0, (1 << DW) - 1));
            rb = VW'($urandom_range(0, (1 << VW) - 1));
            do_div(ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
